// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
//
// Response checker for the logic-gate library.  Each accepted vector (a, b, z)
// is compared against the expected result of the gate selected at run start.
// Vectors and mismatches are counted, and pass/fail is reported once
// NUM_VECTORS vectors have been checked.
//
// Optional feature macro: GATE_CHECK_CAPTURE_EN
//   When defined, first_err_a / first_err_b / first_err_z are added.  They hold
//   the operands and DUT output of the first mismatching vector of the run.
//
// Parameters:
//   WIDTH        operand/result width
//   NUM_VECTORS  vectors checked per run (1 .. 2^CNT_W-1)
//   CNT_W        width of the count/index outputs
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          begin a run (accepted in IDLE or DONE only)
//   op             gate select, latched on accepted start
//                  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a
//   sample_valid   a/b/z valid this cycle
//   a, b           operands applied to the gate DUT
//   z              gate DUT output
//   busy           high while a run is in progress (RUN, DRAIN)
//   done           run complete, held until the next accepted start
//   pass           with done: no mismatches in the run
//   vec_count      vectors accepted this run
//   err_count      mismatching vectors, saturating
//   first_err_idx  0-based index of the first mismatching vector
//   first_err_mask expected XOR z of the first mismatching vector
// -----------------------------------------------------------------------------

// Elaboration-time parameter range checks for gate_response_checker.
module gate_response_checker_cfg_chk #(
    parameter int NUM_VECTORS = 10,
    parameter int CNT_W       = 8
) ();

    if ((NUM_VECTORS < 1) || (NUM_VECTORS > ((1 << CNT_W) - 1))) begin : g_cfg_bad
        $fatal(1, "gate_response_checker: NUM_VECTORS must be in 1 .. 2^CNT_W-1");
    end

endmodule

module gate_response_checker #(
    parameter int WIDTH       = 5,
    parameter int NUM_VECTORS = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_mask
`ifdef GATE_CHECK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH-1:0] first_err_z
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    gate_response_checker_cfg_chk #(
        .NUM_VECTORS (NUM_VECTORS),
        .CNT_W       (CNT_W)
    ) u_cfg_chk ();

    // Expected gate output for the selected operation; NOT/BUF ignore y.
    function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0]       sel,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (sel)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = ~(x & y);
            3'd3:    r = ~(x | y);
            3'd4:    r = x ^ y;
            3'd5:    r = ~(x ^ y);
            3'd6:    r = ~x;
            3'd7:    r = x;
            default: r = x;
        endcase
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       op_r;

    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             pass_nxt_s;

    logic [CNT_W-1:0] vec_count_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] first_err_idx_r;
    logic [WIDTH-1:0] first_err_mask_r;
    logic             first_seen_r;

    // Stage-1 pipeline registers (vector captured on its accept edge)
    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_exp_r;
    logic [WIDTH-1:0] s1_z_r;
    logic [CNT_W-1:0] s1_idx_r;

`ifdef GATE_CHECK_CAPTURE_EN
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [WIDTH-1:0] first_err_a_r;
    logic [WIDTH-1:0] first_err_b_r;
    logic [WIDTH-1:0] first_err_z_r;
`endif

    logic             start_acc_s;
    logic             accept_s;
    logic             last_acc_s;
    logic             mismatch_s;

    assign start_acc_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign accept_s    = sample_valid & (state_r == ST_RUN);
    // The accept that brings vec_count up to NUM_VECTORS ends the RUN phase.
    assign last_acc_s  = accept_s & (vec_count_r == LAST_IDX);
    assign mismatch_s  = s1_valid_r & (s1_exp_r != s1_z_r);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_acc_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (start_acc_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode; status flags are registered one edge later.
    // done/pass trail the DONE state by one edge, so pass sees the final
    // err_count and an accepted start drops done on its own edge.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        pass_nxt_s = 1'b0;
        if ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN)) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
        if ((state_r == ST_DONE) && !start_acc_s) begin
            done_nxt_s = 1'b1;
            pass_nxt_s = (err_count_r == CNT_ZERO);
        end else begin
            done_nxt_s = 1'b0;
            pass_nxt_s = 1'b0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            pass_r <= pass_nxt_s;
        end
    end

    // Gate select, latched only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 3'd0;
        end else if (start_acc_s) begin
            op_r <= op;
        end else begin
            op_r <= op_r;
        end
    end

    // Stage 1: capture the accepted vector with its expected result and index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_exp_r   <= W_ZERO;
            s1_z_r     <= W_ZERO;
            s1_idx_r   <= CNT_ZERO;
`ifdef GATE_CHECK_CAPTURE_EN
            s1_a_r     <= W_ZERO;
            s1_b_r     <= W_ZERO;
`endif
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_exp_r <= gate_eval(op_r, a, b);
                s1_z_r   <= z;
                s1_idx_r <= vec_count_r;
`ifdef GATE_CHECK_CAPTURE_EN
                s1_a_r   <= a;
                s1_b_r   <= b;
`endif
            end else begin
                s1_exp_r <= s1_exp_r;
                s1_z_r   <= s1_z_r;
                s1_idx_r <= s1_idx_r;
            end
        end
    end

    // Accepted-vector counter, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count_r <= CNT_ZERO;
        end else if (start_acc_s) begin
            vec_count_r <= CNT_ZERO;
        end else if (accept_s && (vec_count_r != CNT_MAX)) begin
            vec_count_r <= vec_count_r + CNT_ONE;
        end else begin
            vec_count_r <= vec_count_r;
        end
    end

    // Stage 2: mismatch counter, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= CNT_ZERO;
        end else if (start_acc_s) begin
            err_count_r <= CNT_ZERO;
        end else if (mismatch_s && (err_count_r != CNT_MAX)) begin
            err_count_r <= err_count_r + CNT_ONE;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    // Stage 2: first-error capture, armed once per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_seen_r     <= 1'b0;
            first_err_idx_r  <= CNT_ZERO;
            first_err_mask_r <= W_ZERO;
`ifdef GATE_CHECK_CAPTURE_EN
            first_err_a_r    <= W_ZERO;
            first_err_b_r    <= W_ZERO;
            first_err_z_r    <= W_ZERO;
`endif
        end else if (start_acc_s) begin
            first_seen_r     <= 1'b0;
            first_err_idx_r  <= CNT_ZERO;
            first_err_mask_r <= W_ZERO;
`ifdef GATE_CHECK_CAPTURE_EN
            first_err_a_r    <= W_ZERO;
            first_err_b_r    <= W_ZERO;
            first_err_z_r    <= W_ZERO;
`endif
        end else if (mismatch_s && !first_seen_r) begin
            first_seen_r     <= 1'b1;
            first_err_idx_r  <= s1_idx_r;
            first_err_mask_r <= s1_exp_r ^ s1_z_r;
`ifdef GATE_CHECK_CAPTURE_EN
            first_err_a_r    <= s1_a_r;
            first_err_b_r    <= s1_b_r;
            first_err_z_r    <= s1_z_r;
`endif
        end else begin
            first_seen_r     <= first_seen_r;
            first_err_idx_r  <= first_err_idx_r;
            first_err_mask_r <= first_err_mask_r;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign vec_count      = vec_count_r;
    assign err_count      = err_count_r;
    assign first_err_idx  = first_err_idx_r;
    assign first_err_mask = first_err_mask_r;
`ifdef GATE_CHECK_CAPTURE_EN
    assign first_err_a    = first_err_a_r;
    assign first_err_b    = first_err_b_r;
    assign first_err_z    = first_err_z_r;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: random operands, a
// behavioural gate/run model, directed run scenarios and two large-count
// instances for the saturation boundaries.
module tb_gate_response_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start_big;
    logic [2:0] op;
    logic       sample_valid;
    logic [4:0] a, b, z, z_inv;

    logic       busy, done, pass;
    logic [7:0] vec_count, err_count, first_err_idx;
    logic [4:0] first_err_mask;

    logic       busy_b, done_b, pass_b;
    logic [8:0] vec_count_b, err_count_b, first_err_idx_b;
    logic [4:0] first_err_mask_b;

    logic       busy_s, done_s, pass_s;
    logic [7:0] vec_count_s, err_count_s, first_err_idx_s;
    logic [4:0] first_err_mask_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_response_checker #(.WIDTH(5), .NUM_VECTORS(10), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .sample_valid(sample_valid), .a(a), .b(b), .z(z),
        .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_mask(first_err_mask)
    );

    gate_response_checker #(.WIDTH(5), .NUM_VECTORS(300), .CNT_W(9)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start_big), .op(op),
        .sample_valid(sample_valid), .a(a), .b(b), .z(z_inv),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .vec_count(vec_count_b), .err_count(err_count_b),
        .first_err_idx(first_err_idx_b), .first_err_mask(first_err_mask_b)
    );

    gate_response_checker #(.WIDTH(5), .NUM_VECTORS(255), .CNT_W(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_big), .op(op),
        .sample_valid(sample_valid), .a(a), .b(b), .z(z_inv),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .vec_count(vec_count_s), .err_count(err_count_s),
        .first_err_idx(first_err_idx_s), .first_err_mask(first_err_mask_s)
    );

    // Reference gate: pick the base function, then invert for the negated gates.
    function automatic logic [4:0] ref_gate(input int g, input logic [4:0] x, input logic [4:0] y);
        logic [4:0] r;
        if (g == 0 || g == 2)      r = x & y;
        else if (g == 1 || g == 3) r = x | y;
        else if (g == 4 || g == 5) r = x ^ y;
        else                       r = x;
        if (g == 2 || g == 3 || g == 5 || g == 6) r = ~r;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run on the main instance, with the model tracking the
    // accepted vectors, mismatches and the first error.
    task automatic do_run(input logic [2:0] gop, input bit gaps, input int bad_idx,
                          input logic [4:0] bad_mask, input bit rand_err, input bit disturb);
        int acc = 0;
        int errs = 0;
        int first = -1;
        int cyc = 0;
        logic [4:0] fmask = 5'd0;
        logic [4:0] corrupt;
        op = gop;
        start = 1'b1;
        sample_valid = 1'b0;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_pass", 32'(pass), 32'd0);
        check("start_vec", 32'(vec_count), 32'd0);
        check("start_err", 32'(err_count), 32'd0);
        check("start_fidx", 32'(first_err_idx), 32'd0);
        check("start_fmask", 32'(first_err_mask), 32'd0);
        while (acc < 10) begin
            sample_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            if (disturb && cyc == 3) begin
                start = 1'b1;
                op = gop + 3'd1;
            end else begin
                start = 1'b0;
            end
            a = 5'($urandom);
            b = 5'($urandom);
            if (acc == bad_idx) corrupt = bad_mask;
            else if (rand_err && $urandom_range(0, 3) == 0) corrupt = 5'($urandom_range(1, 31));
            else corrupt = 5'd0;
            z = ref_gate(int'(gop), a, b) ^ corrupt;
            if (sample_valid) begin
                if (corrupt != 5'd0) begin
                    errs++;
                    if (first < 0) begin
                        first = acc;
                        fmask = corrupt;
                    end
                end
                acc++;
            end
            tick();
            cyc++;
            check("run_vec", 32'(vec_count), 32'(acc));
            check("run_busy", 32'(busy), 32'd1);
        end
        sample_valid = 1'b0;
        start = 1'b0;
        tick();
        check("drain_err", 32'(err_count), 32'(errs));
        check("drain_busy", 32'(busy), 32'd0);
        tick();
        check("done", 32'(done), 32'd1);
        check("pass", 32'(pass), (errs == 0) ? 32'd1 : 32'd0);
        check("vec_count", 32'(vec_count), 32'd10);
        check("err_count", 32'(err_count), 32'(errs));
        check("first_err_idx", 32'(first_err_idx), (first < 0) ? 32'd0 : 32'(first));
        check("first_err_mask", 32'(first_err_mask), 32'(fmask));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_big = 1'b0;
        op = 3'd0;
        sample_valid = 1'b0;
        a = 5'd0; b = 5'd0; z = 5'd0; z_inv = 5'd0;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_vec", 32'(vec_count), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_fidx", 32'(first_err_idx), 32'd0);
        check("rst_fmask", 32'(first_err_mask), 32'd0);
        rst_n = 1'b1;
        tick();

        // Clean NOR run, valid every cycle
        do_run(3'd3, 1'b0, -1, 5'd0, 1'b0, 1'b0);
        // NOR with a single wrong bit on vector 3
        do_run(3'd3, 1'b0, 3, 5'b00100, 1'b0, 1'b0);
        check("t2_fidx", 32'(first_err_idx), 32'd3);
        check("t2_fmask", 32'(first_err_mask), 32'h04);
        // AND with sample_valid toggling, then a restart from DONE
        do_run(3'd0, 1'b1, -1, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
        check("held_done", 32'(done), 32'd1);
        check("held_pass", 32'(pass), 32'd1);
        check("held_vec", 32'(vec_count), 32'd10);
        do_run(3'd0, 1'b1, 6, 5'b10001, 1'b0, 1'b0);
        // op change and start pulse during RUN must be ignored
        do_run(3'd4, 1'b0, -1, 5'd0, 1'b0, 1'b1);
        do_run(3'd1, 1'b1, 7, 5'b11111, 1'b0, 1'b1);

        // Reset in the middle of a run
        op = 3'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            a = 5'($urandom);
            b = 5'($urandom);
            z = ref_gate(5, a, b) ^ ((i == 1) ? 5'b01000 : 5'd0);
            tick();
        end
        sample_valid = 1'b0;
        check("pre_rst_vec", 32'(vec_count), 32'd4);
        check("pre_rst_err", 32'(err_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_pass", 32'(pass), 32'd0);
        check("mid_rst_vec", 32'(vec_count), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        check("mid_rst_fidx", 32'(first_err_idx), 32'd0);
        check("mid_rst_fmask", 32'(first_err_mask), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        do_run(3'd5, 1'b0, -1, 5'd0, 1'b0, 1'b0);

        // Every gate with random corruption
        for (int g = 0; g < 8; g++) begin
            do_run(3'(g), (g % 2) == 1, -1, 5'd0, 1'b1, 1'b0);
        end

        // Large runs: every output inverted, 300 and 255 vectors
        op = 3'd4;
        start_big = 1'b1;
        tick();
        start_big = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sample_valid = 1'b1;
            a = 5'($urandom);
            b = 5'($urandom);
            z_inv = ~ref_gate(4, a, b);
            tick();
        end
        sample_valid = 1'b0;
        repeat (2) tick();
        check("big_done", 32'(done_b), 32'd1);
        check("big_busy", 32'(busy_b), 32'd0);
        check("big_pass", 32'(pass_b), 32'd0);
        check("big_vec", 32'(vec_count_b), 32'd300);
        check("big_err", 32'(err_count_b), 32'd300);
        check("big_fidx", 32'(first_err_idx_b), 32'd0);
        check("big_fmask", 32'(first_err_mask_b), 32'h1f);
        check("sat_done", 32'(done_s), 32'd1);
        check("sat_busy", 32'(busy_s), 32'd0);
        check("sat_pass", 32'(pass_s), 32'd0);
        check("sat_vec", 32'(vec_count_s), 32'd255);
        check("sat_err", 32'(err_count_s), 32'd255);
        check("sat_fidx", 32'(first_err_idx_s), 32'd0);
        check("sat_fmask", 32'(first_err_mask_s), 32'h1f);
        check("main_idle_done", 32'(done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Synthesizable response checker for the logic-gate library: the receiving end of the random-stimulus flow.
- Samples each applied operand pair (a, b) with the gate output z and computes the expected result for the selected gate.
- Counts vectors and mismatches and reports pass/fail once a programmed number of vectors has been checked.
- Sits beside any gate DUT in a bench or on-chip self-test wrapper.

Parameters:
WIDTH, 5, operand/result bit width
NUM_VECTORS, 10, vectors to check per run (>=1)
CNT_W, 8, width of vec_count and err_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; accepted in IDLE or DONE only
op  input  3  gate select, latched on accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a
sample_valid  input  1  a/b/z valid this cycle
a  input  WIDTH  operand A applied to DUT
b  input  WIDTH  operand B applied to DUT
z  input  WIDTH  DUT output
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE, held until next accepted start
pass  output  1  in DONE: 1 when err_count == 0; 0 otherwise
vec_count  output  CNT_W  vectors accepted this run
err_count  output  CNT_W  mismatching vectors, saturating
first_err_idx  output  CNT_W  index (0-based) of first mismatching vector
first_err_mask  output  WIDTH  expected XOR z of first mismatching vector

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; pipeline valid flag cleared. Reset mid-run aborts immediately with no partial result retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start=1: next cycle RUN. vec_count, err_count, first_err_idx, first_err_mask and the internal first-error flag are cleared. op is latched. done drops.
- RUN: each cycle with sample_valid=1 is accepted.
  - Stage 1 (accept edge): register a, b, z, expected = f(op_latched, a, b) and the vector index. vec_count increments.
  - sample_valid gaps are allowed; no timeout.
- Stage 2 (next edge): mismatch when expected != z, full WIDTH compared.
  - On mismatch, err_count increments, saturating at 2^CNT_W-1.
  - On the first mismatch of the run, also capture first_err_idx and first_err_mask.
- When the accept raises vec_count to NUM_VECTORS: RUN -> DRAIN. DRAIN lasts one cycle and completes stage 2 of the last vector. Then DONE.
- Latency: final vector accepted at edge N; err_count final at edge N+1; done=1 and pass valid after edge N+2.
- sample_valid is ignored in IDLE, DRAIN and DONE. start is ignored in RUN and DRAIN. op changes outside an accepted start have no effect.
- NOT/BUF ops ignore b.
- vec_count saturates at 2^CNT_W-1. NUM_VECTORS must be <= 2^CNT_W-1; this is checked by an elaboration-time assertion.
- pass is 0 in every state other than DONE.

Optional Feature:
GATE_CHECK_CAPTURE_EN
- Defined: adds outputs first_err_a, first_err_b, first_err_z (each WIDTH).
  - They latch the stage-1 operands and output of the first mismatching vector, at the same edge as first_err_idx.
  - They are cleared on reset and on accepted start.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Correct NOR DUT, op=3, 10 random vectors with sample_valid every cycle -> after edge N+2: done=1, pass=1, vec_count=10, err_count=0, first_err_mask=0.
- op=3, z forced to expected^5'b00100 on vector 3 only -> err_count=1, first_err_idx=3, first_err_mask=5'b00100, pass=0.
- op=0 (AND), sample_valid toggling 1/0, second run started from DONE -> counts cleared at restart; 10 accepts needed per run; done held between runs.
- op changed and start pulsed during RUN -> ignored; result uses original op; vec_count unaffected.
- rst_n asserted after 4 vectors -> immediately IDLE with all outputs 0; a new start runs a clean full 10-vector check.
- NUM_VECTORS=300, CNT_W=9, every z inverted -> err_count=300 with no saturation. With CNT_W=8 and NUM_VECTORS=255 all wrong -> err_count=255, first_err_idx=0.
